network_if_rr_arbiter: RTL and testbench
========================================

# network_if_rr_arbiter

Round-robin arbiter that merges `NUM_IN` `network_if` slave streams onto one `network_if` master stream. It has a single registered output stage with full throughput. A configurable burst hold keeps the grant on one requester for up to `MAX_BURST` consecutive beats. It sits in front of shared network datapath resources, such as a single pipeline or copier, that several producers must time-share.

## Interface
- `NUM_IN`, 4, number of input streams; ≥ 2.
- `MAX_BURST`, 1, maximum consecutive accepted beats per grant; ≥ 1. A value of 1 gives pure per-beat round-robin.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in[NUM_IN]`  `network_if.slave`  –  requester streams (`val`, `id`, `valid`, `ready`).
- `out`  `network_if.master`  –  merged stream.
- `grant_idx`  output  `$clog2(NUM_IN)`  index of the input that delivered the beat currently in the output register; debug only.

Widths:
- `in.val` / `in.id` are cast to `out.IN_WIDTH` / `out.ID_WIDTH`.
- Values are zero-extended when the output is wider and truncated when it is narrower.

## Operation
- **Output register.** One entry holds `out.val`, `out.id`, `out.valid` and `grant_idx`.
  - `load = !out.valid || out.ready`.
- **Ready.** `in[i].ready = load && (i == sel)`. At most one input is ready in any cycle.
- **Selection `sel`** (combinational, from state):
  - `IDLE`: first `i` with `in[i].valid`, searching cyclically from `(last + 1) mod NUM_IN`.
  - `LOCKED`: `sel = owner`.
- **Accept.** `accept = load && in[sel].valid`. On accept, the output register loads the `in[sel]` data and sets `out.valid = 1`.
- **Drain.** `load && !accept` clears `out.valid`. Data registers may hold stale values while `out.valid = 0`.
- **State machine** (`owner`, `last`, `beats`):
  - `IDLE` → `LOCKED` on accept when `MAX_BURST > 1`. Sets `owner = sel`, `beats = 1`.
  - `IDLE` stays `IDLE` on accept when `MAX_BURST == 1`, with `last = sel`.
  - `LOCKED`, accept with `beats + 1 == MAX_BURST`: → `IDLE`, `last = owner`.
  - `LOCKED`, accept otherwise: `beats++`.
  - `LOCKED`, `load && !in[owner].valid`: → `IDLE`, `last = owner`. The lock is released with no beat taken, so the next cycle arbitrates among the others first.
  - `LOCKED`, `!load`: hold. A stalled output never releases or rotates the grant.
- **Stability.** While `out.valid && !out.ready`, the `out.val`/`out.id` outputs are held stable.
- **Inputs.** Inputs must hold `val`/`id` stable while `valid && !ready` (standard handshake). The arbiter does not check this.

## Timing
- **Reset values** (async assert, sync deassert is the system's concern):
  - `out.valid = 0`, `out.val = 0`, `out.id = 0`, `grant_idx = 0`.
  - State `IDLE`, `last = NUM_IN-1` (input 0 has first priority), `beats = 0`.
  - All `in[i].ready` are 0 during reset.
- **Latency.** 1 cycle from accept on `in[sel]` to `out.valid`.
- **Throughput.** 1 beat/cycle sustained when `out.ready` is held high, including across grant changes. There are no bubbles between requesters.
- **Simultaneous events.** In the same cycle, a downstream pop (`out.ready`) and a new accept both occur: the register reloads and `out.valid` stays 1.
- **No valid inputs.** `IDLE` with no valid inputs: nothing is accepted, and `last` does not change.
- **Mid-transfer reset.** Reset mid-burst discards the register contents and the lock. After release, arbitration restarts from input 0.
- **Counter width.** `beats` counts to `MAX_BURST-1`; its width is `$clog2(MAX_BURST+1)`.

## Configuration
- **`NETWORK_IF_ARB_STATS_EN` defined:**
  - Adds output port `grant_count[NUM_IN]`, 32 bits each.
  - `grant_count[i]` increments on every accept from `in[i]` and wraps modulo 2^32.
  - Reset value is 0.
- **Not defined:** the port and counters are absent; behaviour is otherwise identical.

## Test plan
- **Round-robin, `MAX_BURST = 1`, `NUM_IN = 4`:**
  - Stimulus: all inputs always valid, with `in[i].val = i*16 + beat`; `out.ready = 1`.
  - Required response: outputs from inputs 0, 1, 2, 3, 0, … on consecutive cycles, starting 1 cycle after reset release, with no gaps.
- **Burst, `MAX_BURST = 3`:**
  - Stimulus: inputs 1 and 2 always valid.
  - Required response: beat sequence 1,1,1,2,2,2,1,…. `grant_idx` matches the source of each beat.
- **Early release, `MAX_BURST = 4`:**
  - Stimulus: input 0 is valid for 2 beats then drops; input 3 is valid.
  - Required response: 0,0, then input 3 beats on the following cycles. At most one idle cycle appears on `out.valid` (the release cycle).
- **Backpressure:**
  - Stimulus: `out.ready = 0` for 5 cycles mid-burst.
  - Required response: `out.val`/`out.id` stable, all `in.ready = 0`, and `beats` unchanged. On resume the order continues with no loss or duplication; the scoreboard compares against per-input FIFOs.
- **Width cast:**
  - Stimulus: `in.IN_WIDTH = 8`, `out.IN_WIDTH = 16`, `in.val = 8'hA5`.
  - Required response: `out.val = 16'h00A5`.
  - Stimulus: `in.ID_WIDTH = 6`, `out.ID_WIDTH = 4`, `in.id = 6'h2B`.
  - Required response: `out.id = 4'hB`.
- **Reset mid-burst, with `NETWORK_IF_ARB_STATS_EN` defined:**
  - Stimulus: assert `rst_n = 0` asynchronously mid-burst.
  - Required response: `out.valid` drops immediately and `grant_count` clears to 0. After release, input 0 wins first, and its count reads 1 after one accept.

Source files
------------

// File: rtl/network_if_if.sv
// Handshaked value/id stream: a master drives val/id/valid, a slave answers with ready.
interface network_if #(
  parameter int IN_WIDTH = 32,
  parameter int ID_WIDTH = 8
);
  logic [IN_WIDTH-1:0] val;
  logic [ID_WIDTH-1:0] id;
  logic                valid;
  logic                ready;

  modport master (output val, id, valid, input ready);
  modport slave  (input val, id, valid, output ready);
endinterface

// File: rtl/network_if_rr_arbiter.sv
// Round-robin merge of NUM_IN network_if streams with burst hold and a single output register.
// Define NETWORK_IF_ARB_STATS_EN to add per-input 32-bit grant counters (grant_count).
module network_if_rr_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int MAX_BURST = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  network_if.slave                  in [NUM_IN],
  network_if.master                 out,
  output logic [$clog2(NUM_IN)-1:0] grant_idx
`ifdef NETWORK_IF_ARB_STATS_EN
  ,
  output logic [31:0]               grant_count [NUM_IN]
`endif
);

  localparam int IW = $clog2(NUM_IN);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int VW = $bits(out.val);
  localparam int DW = $bits(out.id);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last;
  logic [BW-1:0]   beats;
  logic [IW-1:0]   sel;
  logic            load;
  logic            accept;

  logic [VW-1:0]   vals   [NUM_IN];
  logic [DW-1:0]   ids    [NUM_IN];
  logic [NUM_IN-1:0] valids;

  logic [VW-1:0]   val_p1;
  logic [DW-1:0]   id_p1;
  logic            vld_p1;
  logic [IW-1:0]   grant_p1;

  // Inputs are resized to the output widths here: zero-extend or truncate.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign vals[g]     = VW'(in[g].val);
    assign ids[g]      = DW'(in[g].id);
    assign valids[g]   = in[g].valid;
    assign in[g].ready = rst_n && load && (sel == IW'(g));
  end

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    sel   = owner;
    found = 1'b0;
    cand  = '0;
    if (state == IDLE) begin
      sel = last;
      for (int k = 1; k <= NUM_IN; k++) begin
        cand = IW'((int'(last) + k) % NUM_IN);
        if (!found && valids[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load   = !vld_p1 || out.ready;
    accept = load && valids[sel];
  end

  // Stage p1: output register plus grant state; nothing moves while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= IW'(NUM_IN - 1);
      beats    <= '0;
      vld_p1   <= 1'b0;
      val_p1   <= '0;
      id_p1    <= '0;
      grant_p1 <= '0;
    end else if (load) begin
      vld_p1 <= accept;
      if (accept) begin
        val_p1   <= vals[sel];
        id_p1    <= ids[sel];
        grant_p1 <= sel;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (MAX_BURST > 1) begin
              state <= LOCKED;
              owner <= sel;
              beats <= BW'(1);
            end else begin
              last <= sel;
            end
          end
        end
        LOCKED: begin
          if (accept && (int'(beats) + 1 != MAX_BURST)) begin
            beats <= beats + BW'(1);
          end else begin
            // Burst complete or owner went idle: rotate past the owner.
            state <= IDLE;
            last  <= owner;
            beats <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out.val   = val_p1;
  assign out.id    = id_p1;
  assign out.valid = vld_p1;
  assign grant_idx = grant_p1;

`ifdef NETWORK_IF_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) grant_count[i] <= '0;
    end else if (accept) begin
      grant_count[sel] <= grant_count[sel] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_network_if_rr_arbiter.sv
// Randomized scoreboard bench for network_if_rr_arbiter (MAX_BURST=3 main DUT, MAX_BURST=1 rotation DUT).
`timescale 1ns/1ps
module tb_network_if_rr_arbiter;
  localparam int N  = 4;
  localparam int MB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n    = 1'b0;
  logic rr_rst_n = 1'b0;

  network_if #(.IN_WIDTH(8),  .ID_WIDTH(6)) in_if [N] ();
  network_if #(.IN_WIDTH(16), .ID_WIDTH(4)) out_if ();
  network_if #(.IN_WIDTH(8),  .ID_WIDTH(6)) rr_in [N] ();
  network_if #(.IN_WIDTH(16), .ID_WIDTH(4)) rr_out ();
  logic [1:0] grant_idx, rr_grant;
`ifdef NETWORK_IF_ARB_STATS_EN
  logic [31:0] grant_count [N];
  logic [31:0] rr_count [N];
`endif

  network_if_rr_arbiter #(.NUM_IN(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_if), .out(out_if), .grant_idx(grant_idx)
`ifdef NETWORK_IF_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  network_if_rr_arbiter #(.NUM_IN(N), .MAX_BURST(1)) rr_dut (
    .clk(clk), .rst_n(rr_rst_n), .in(rr_in), .out(rr_out), .grant_idx(rr_grant)
`ifdef NETWORK_IF_ARB_STATS_EN
    , .grant_count(rr_count)
`endif
  );

  logic         drv_valid [N];
  logic [7:0]   drv_val   [N];
  logic [5:0]   drv_id    [N];
  logic [N-1:0] rdy;
  logic         o_ready;
  logic [7:0]   rr_val [N];
  logic [N-1:0] rr_rdy;

  for (genvar g = 0; g < N; g++) begin : g_if
    assign in_if[g].valid = drv_valid[g];
    assign in_if[g].val   = drv_val[g];
    assign in_if[g].id    = drv_id[g];
    assign rdy[g]         = in_if[g].ready;
    assign rr_in[g].valid = 1'b1;
    assign rr_in[g].val   = rr_val[g];
    assign rr_in[g].id    = 6'(g);
    assign rr_rdy[g]      = rr_in[g].ready;
  end
  assign out_if.ready = o_ready;
  assign rr_out.ready = 1'b1;

  typedef struct {
    int         src;
    logic [15:0] val;
    logic [3:0]  id;
  } exp_t;

  exp_t sb[$];
  exp_t rr_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: who should own the output next, from the arbitration rules.
  int   m_holder, m_taken, m_last;
  logic m_vld;
  int   m_cnt [N];
  int   pv [N];
  int   budget [N];
  int   p_ready;
  bit   fixed_pat;
  logic [N-1:0] took;

  task automatic model_reset();
    m_holder = -1;
    m_taken  = 0;
    m_last   = N - 1;
    m_vld    = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  task automatic model_step();
    int win;
    bit load;
    exp_t e;
    win  = -1;
    load = !m_vld || o_ready;
    if (load) begin
      if (m_holder >= 0) begin
        if (drv_valid[m_holder]) win = m_holder;
        else begin
          m_last   = m_holder;
          m_holder = -1;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (win < 0 && drv_valid[c]) win = c;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (drv_valid[i]) check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(i == win));
    if (load) begin
      m_vld = (win >= 0);
      if (win >= 0) begin
        e.src = win;
        e.val = {8'h00, drv_val[win]};
        e.id  = drv_id[win][3:0];
        sb.push_back(e);
        m_cnt[win]++;
        if (m_holder < 0) begin
          if (MB > 1) begin
            m_holder = win;
            m_taken  = 1;
          end else m_last = win;
        end else begin
          m_taken++;
          if (m_taken == MB) begin
            m_last   = m_holder;
            m_holder = -1;
          end
        end
      end
    end
  endtask

  task automatic gen_inputs();
    for (int i = 0; i < N; i++) begin
      if (took[i]) begin
        drv_valid[i] = 1'b0;
        if (budget[i] > 0) budget[i]--;
      end
      if (!drv_valid[i] && budget[i] != 0 && $urandom_range(99) < pv[i]) begin
        drv_valid[i] = 1'b1;
        if (fixed_pat) begin
          drv_val[i] = 8'hA5;
          drv_id[i]  = 6'h2B;
        end else begin
          drv_val[i] = 8'($urandom);
          drv_id[i]  = 6'($urandom);
        end
      end
    end
    o_ready = ($urandom_range(99) < p_ready);
  endtask

  task automatic cycle();
    @(negedge clk);
    check("out_valid", 32'(out_if.valid), 32'(m_vld));
`ifdef NETWORK_IF_ARB_STATS_EN
    for (int i = 0; i < N; i++) check($sformatf("grant_count%0d", i), grant_count[i], m_cnt[i]);
`endif
    for (int i = 0; i < N; i++) took[i] = drv_valid[i] && rdy[i];
    model_step();
    @(posedge clk);
    #1;
    gen_inputs();
  endtask

  task automatic set_pv(input int a, input int b, input int c, input int d);
    pv[0] = a; pv[1] = b; pv[2] = c; pv[3] = d;
  endtask

  // Monitor: pop the scoreboard whenever a beat leaves either DUT.
  logic        held;
  logic [15:0] hval;
  logic [3:0]  hid;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) held = 1'b0;
    else begin
      if (held) begin
        check("hold_val", 32'(out_if.val), 32'(hval));
        check("hold_id", 32'(out_if.id), 32'(hid));
      end
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got beat val=%0h, expected none", out_if.val);
        end else begin
          e = sb.pop_front();
          check("out_val", 32'(out_if.val), 32'(e.val));
          check("out_id", 32'(out_if.id), 32'(e.id));
          check("grant_idx", 32'(grant_idx), 32'(e.src));
        end
      end
      held = out_if.valid && !out_if.ready;
      hval = out_if.val;
      hid  = out_if.id;
    end
    if (rr_rst_n && rr_out.valid) begin
      if (rr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rr_underflow: got beat val=%0h, expected none", rr_out.val);
      end else begin
        e = rr_q.pop_front();
        check("rr_val", 32'(rr_out.val), 32'(e.val));
        check("rr_id", 32'(rr_out.id), 32'(e.id));
        check("rr_grant", 32'(rr_grant), 32'(e.src));
      end
    end
  end

  // Pure rotation DUT: every input always valid, in[i].val = i*16 + beat.
  int   rr_next = 0;
  logic rr_m_vld = 1'b0;
  int   rr_mcnt [N];
  int   rr_dcnt [N];
  logic [N-1:0] rr_took;
  initial begin : rr_drv
    exp_t e;
    for (int i = 0; i < N; i++) begin
      rr_mcnt[i] = 0;
      rr_dcnt[i] = 0;
      rr_val[i]  = 8'(i * 16);
    end
    wait (rr_rst_n);
    forever begin
      @(negedge clk);
      check("rr_valid", 32'(rr_out.valid), 32'(rr_m_vld));
      check("rr_ready", 32'(rr_rdy), 32'(1 << rr_next));
      e.src = rr_next;
      e.val = {8'h00, 8'(rr_next * 16 + rr_mcnt[rr_next])};
      e.id  = 4'(rr_next);
      rr_q.push_back(e);
      rr_mcnt[rr_next]++;
      rr_next  = (rr_next + 1) % N;
      rr_m_vld = 1'b1;
      rr_took  = rr_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (rr_took[i]) begin
          rr_dcnt[i]++;
          rr_val[i] = 8'(i * 16 + rr_dcnt[i]);
        end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = 1'b0;
      drv_val[i]   = 8'h00;
      drv_id[i]    = 6'h00;
      budget[i]    = -1;
    end
    drv_valid[0] = 1'b1;
    drv_val[0]   = 8'h3C;
    drv_id[0]    = 6'h15;
    took      = '0;
    o_ready   = 1'b1;
    p_ready   = 100;
    fixed_pat = 1'b0;
    set_pv(0, 0, 0, 0);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_if.valid), 32'd0);
    check("rst_val", 32'(out_if.val), 32'd0);
    check("rst_id", 32'(out_if.id), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_ready", 32'(rdy), 32'd0);
    check("rr_rst_ready", 32'(rr_rdy), 32'd0);
    rst_n    = 1'b1;
    rr_rst_n = 1'b1;

    // Inputs 1 and 2 contend: bursts of three each.
    set_pv(0, 100, 100, 0);
    repeat (24) cycle();
    set_pv(0, 0, 0, 0);
    repeat (6) cycle();

    // Input 0 offers two beats then goes idle while input 3 waits.
    budget[0] = 2;
    set_pv(100, 0, 0, 0);
    cycle();
    set_pv(100, 0, 0, 100);
    repeat (10) cycle();
    set_pv(0, 0, 0, 0);
    repeat (6) cycle();
    budget[0] = -1;

    // Downstream stall in the middle of a burst.
    set_pv(100, 100, 100, 100);
    repeat (4) cycle();
    p_ready = 0;
    repeat (5) cycle();
    p_ready = 100;
    repeat (8) cycle();

    // Width cast with a fixed pattern on input 2.
    set_pv(0, 0, 0, 0);
    repeat (6) cycle();
    fixed_pat = 1'b1;
    budget[2] = 3;
    set_pv(0, 0, 100, 0);
    repeat (8) cycle();
    fixed_pat = 1'b0;
    budget[2] = -1;

    // Random traffic with random backpressure.
    for (int i = 0; i < N; i++) pv[i] = 30 + $urandom_range(60);
    p_ready = 70;
    repeat (300) cycle();

    // Asynchronous reset in the middle of a burst.
    set_pv(100, 100, 100, 100);
    p_ready = 100;
    repeat (5) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_if.valid), 32'd0);
    check("midrst_ready", 32'(rdy), 32'd0);
`ifdef NETWORK_IF_ARB_STATS_EN
    for (int i = 0; i < N; i++) check($sformatf("midrst_count%0d", i), grant_count[i], 32'd0);
`endif
    model_reset();
    took = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) cycle();

    // Drain everything still in flight.
    set_pv(0, 0, 0, 0);
    p_ready = 100;
    repeat (12) cycle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
